uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares the debugger unit's single UART transmitter between several word-producing requesters, such as the register dump, memory dump and PC/cycle-count reporters. It grants one requester at a time and latches that requester's word. It splits the word into bytes, least-significant byte first, and sequences each byte into the transmitter through its `tx_start`/`tx_done` handshake. It acknowledges the requester once the last byte's stop bit completes.

---
 rtl/uart_tx_scheduler.sv | 140 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Round-robin scheduler that shares one UART transmitter between NUM_REQ
//   word producers. The winning requester's word is latched, then sent LSB
//   byte first through the transmitter's tx_start/tx_done handshake. The
//   requester is acknowledged after the last byte's stop bit.
//
// Ports
//   clk       system clock
//   rst       asynchronous, active-low reset
//   req       request level, one bit per requester
//   word_in   packed words, requester i at [i*LEN_WORD +: LEN_WORD]
//   tx_done   one-cycle pulse from the transmitter at end of stop bit
//   tx_start  one-cycle pulse that starts a byte
//   tx_data   byte presented to the transmitter
//   ack       one-hot, one-cycle pulse: requester's word fully sent
//   busy      high whenever the scheduler is not idle
//   grant_id  index of the current or most recent grantee
module uart_tx_scheduler #(
    parameter  int unsigned NUM_REQ  = 4,
    parameter  int unsigned LEN_DATA = 8,
    parameter  int unsigned LEN_WORD = 32,
    localparam int unsigned NBYTES   = LEN_WORD / LEN_DATA,
    localparam int unsigned IDW      = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*LEN_WORD-1:0] word_in,
    input  logic                        tx_done,
    output logic                        tx_start,
    output logic [LEN_DATA-1:0]         tx_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        busy,
    output logic [IDW-1:0]              grant_id
);

    localparam int unsigned CNTW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        DONE
    } state_t;

    state_t              state_q,      state_d;
    logic [LEN_WORD-1:0] shreg_q,      shreg_d;
    logic [CNTW-1:0]     byte_cnt_q,   byte_cnt_d;
    logic [IDW-1:0]      grant_q,      grant_d;
    logic [IDW-1:0]      last_grant_q, last_grant_d;

    logic                win_found;
    logic [IDW-1:0]      win_id;
    logic [IDW-1:0]      cand;

    // Round-robin search: start one past the last grantee and take the
    // first requesting index, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IDW'((32'(last_grant_q) + off) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        byte_cnt_d   = byte_cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    shreg_d    = word_in[win_id*LEN_WORD +: LEN_WORD];
                    grant_d    = win_id;
                    byte_cnt_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (byte_cnt_q == CNTW'(NBYTES - 1)) begin
                        state_d = DONE;
                    end else begin
                        shreg_d    = shreg_q >> LEN_DATA;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = SEND;
                    end
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // last_grant resets to NUM_REQ-1 so requester 0 wins first after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            byte_cnt_q   <= '0;
            grant_q      <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            byte_cnt_q   <= byte_cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Handshake outputs come from the state register only, never from req.
    assign tx_start = (state_q == SEND);
    assign busy     = (state_q != IDLE);
    assign tx_data  = shreg_q[LEN_DATA-1:0];
    assign grant_id = grant_q;

    always_comb begin
        ack = '0;
        if (state_q == DONE) begin
            ack[grant_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
//   Directed bench for uart_tx_scheduler with a transmitter model that
//   answers each tx_start with tx_done after tx_lat cycles. Expected bytes
//   and acks are queued when requests are driven and consumed by a monitor.
module tb_uart_tx_scheduler;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] word_in;
    logic         tx_done;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic [3:0]   ack;
    logic         busy;
    logic [1:0]   grant_id;

    logic         tx_done_m;
    logic         tx_done_inj;
    int unsigned  tx_lat;
    int unsigned  cnt;

    int           n_cmp;
    int           n_err;
    int           start_cnt;
    int           ack_cnt [4];
    int           base_ack [4];
    int           s0;

    logic [8:0]   exp_bytes [$];
    logic [3:0]   exp_ack [$];
    logic [1:0]   exp_gid [$];
    logic [8:0]   eb;

    assign tx_done = tx_done_m | tx_done_inj;

    uart_tx_scheduler #(
        .NUM_REQ (4),
        .LEN_DATA(8),
        .LEN_WORD(32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .word_in (word_in),
        .tx_done (tx_done),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .ack     (ack),
        .busy    (busy),
        .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: tx_done pulses tx_lat cycles after tx_start.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 0;
            tx_done_m <= 1'b0;
        end else begin
            tx_done_m <= (cnt == 1);
            if (tx_start) cnt <= tx_lat;
            else if (cnt != 0) cnt <= cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every byte start and every ack is matched against the queues.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            if (tx_start) begin
                start_cnt++;
                if (exp_bytes.size() == 0) begin
                    check("extra_tx_start", 32'(tx_start), 0);
                end else begin
                    eb = exp_bytes.pop_front();
                    check("tx_data", 32'(tx_data), 32'(eb[7:0]));
                    if (!eb[8]) check("start_after_done", 32'(tx_done), 1);
                end
            end
            if (ack != 4'b0) begin
                for (int i = 0; i < 4; i++) if (ack[i]) ack_cnt[i]++;
                if (exp_ack.size() == 0) begin
                    check("extra_ack", 32'(ack), 0);
                end else begin
                    check("ack", 32'(ack), 32'(exp_ack.pop_front()));
                    check("ack_gid", 32'(grant_id), 32'(exp_gid.pop_front()));
                    check("ack_after_done", 32'(tx_done), 1);
                end
            end
        end
    end

    task automatic push_word(input int id, input logic [31:0] w);
        for (int unsigned b = 0; b < 4; b++) begin
            exp_bytes.push_back({(b == 0), w[b*8 +: 8]});
        end
        exp_ack.push_back(4'b0001 << id);
        exp_gid.push_back(2'(id));
    endtask

    task automatic set_word(input int id, input logic [31:0] w);
        word_in[id*32 +: 32] = w;
    endtask

    task automatic wait_busy();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (busy) seen = 1'b1;
        end
        check("busy_seen", 32'(seen), 1);
    endtask

    // Waits for ack[id], then in the following (idle) cycle checks busy and
    // drops the requests in drop_mask.
    task automatic wait_ack(input int id, input logic [3:0] drop_mask);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk); #1;
            if (ack[id]) seen = 1'b1;
        end
        check($sformatf("ack%0d_seen", id), 32'(seen), 1);
        @(posedge clk); #1;
        check("busy_fall", 32'(busy), 0);
        req = req & ~drop_mask;
    endtask

    task automatic snap_acks();
        for (int i = 0; i < 4; i++) base_ack[i] = ack_cnt[i];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; start_cnt = 0;
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        rst = 1'b0; req = '0; word_in = '0; tx_done_inj = 1'b0; tx_lat = 20;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data",  32'(tx_data),  0);
        check("rst_ack",      32'(ack),      0);
        check("rst_busy",     32'(busy),     0);
        check("rst_grant_id", 32'(grant_id), 0);
        @(negedge clk) rst = 1'b1;

        // Reset asserted mid-WAIT aborts the word with no ack
        set_word(2, 32'h55667788);
        req = 4'b0100;
        push_word(2, 32'h55667788);
        wait_busy();
        check("abort_grant", 32'(grant_id), 2);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort_tx_start", 32'(tx_start), 0);
        check("abort_tx_data",  32'(tx_data),  0);
        check("abort_ack",      32'(ack),      0);
        check("abort_busy",     32'(busy),     0);
        check("abort_grant_id", 32'(grant_id), 0);
        exp_bytes.delete(); exp_ack.delete(); exp_gid.delete();
        req = '0;
        @(negedge clk) rst = 1'b1;

        // Simultaneous requests: service 0,1,2,3
        snap_acks();
        set_word(0, 32'hA3A2A1A0); set_word(1, 32'hB3B2B1B0);
        set_word(2, 32'hC3C2C1C0); set_word(3, 32'hD3D2D1D0);
        push_word(0, 32'hA3A2A1A0); push_word(1, 32'hB3B2B1B0);
        push_word(2, 32'hC3C2C1C0); push_word(3, 32'hD3D2D1D0);
        req = 4'b1111;
        wait_busy();
        check("first_after_reset", 32'(grant_id), 0);
        wait_ack(0, 4'b0001);
        wait_ack(1, 4'b0010);
        wait_ack(2, 4'b0100);
        wait_ack(3, 4'b1000);
        for (int i = 0; i < 4; i++) check($sformatf("ack_once%0d", i), 32'(ack_cnt[i] - base_ack[i]), 1);
        check("sim_bytes_left", 32'(exp_bytes.size()), 0);

        // Single word with slow transmitter
        tx_lat = 160;
        s0 = start_cnt;
        set_word(0, 32'hDEADBEEF);
        push_word(0, 32'hDEADBEEF);
        req = 4'b0001;
        wait_ack(0, 4'b0001);
        check("single_starts", 32'(start_cnt - s0), 4);
        tx_lat = 20;

        // Fairness: 0 and 2 held, 1 joins during a word of 0 that follows 2
        set_word(0, 32'h01234567); set_word(2, 32'h89ABCDEF); set_word(1, 32'h5A5AA5A5);
        push_word(2, 32'h89ABCDEF); push_word(0, 32'h01234567);
        push_word(2, 32'h89ABCDEF); push_word(0, 32'h01234567);
        push_word(1, 32'h5A5AA5A5); push_word(2, 32'h89ABCDEF);
        push_word(0, 32'h01234567);
        req = 4'b0101;
        wait_ack(2, 4'b0000);
        wait_ack(0, 4'b0000);
        wait_ack(2, 4'b0000);
        repeat (5) @(posedge clk);
        #1;
        check("fair_mid_grant", 32'(grant_id), 0);
        req[1] = 1'b1;
        wait_ack(0, 4'b0000);
        wait_ack(1, 4'b0010);
        wait_ack(2, 4'b0000);
        wait_ack(0, 4'b0101);
        check("fair_bytes_left", 32'(exp_bytes.size()), 0);

        // Spurious tx_done in IDLE
        tx_done_inj = 1'b1;
        @(posedge clk); #1;
        tx_done_inj = 1'b0;
        check("idle_done_busy",  32'(busy),     0);
        check("idle_done_start", 32'(tx_start), 0);

        // Word latching and spurious tx_done in SEND
        s0 = start_cnt;
        set_word(0, 32'hCAFEF00D);
        push_word(0, 32'hCAFEF00D);
        req = 4'b0001;
        wait_busy();
        set_word(0, 32'h11223344);
        tx_done_inj = 1'b1;
        @(posedge clk); #1;
        tx_done_inj = 1'b0;
        check("send_done_start", 32'(tx_start), 0);
        wait_ack(0, 4'b0001);
        check("latch_starts", 32'(start_cnt - s0), 4);

        // Request withdrawn before grant is never served
        snap_acks();
        set_word(1, 32'h0BADF00D); set_word(3, 32'h77777777);
        push_word(1, 32'h0BADF00D);
        req = 4'b0010;
        wait_busy();
        repeat (3) @(posedge clk);
        #1;
        req[3] = 1'b1;
        @(posedge clk); #1;
        req[3] = 1'b0;
        wait_ack(1, 4'b0010);
        repeat (10) @(posedge clk);
        #1;
        check("withdrawn_ack3", 32'(ack_cnt[3] - base_ack[3]), 0);
        check("withdrawn_busy", 32'(busy), 0);

        check("final_bytes_left", 32'(exp_bytes.size()), 0);
        check("final_acks_left",  32'(exp_ack.size()),   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
